pps_sync_rx: RTL and testbench

PPS_SYNC_RX -- requirements
Module: pps_sync_rx

---
 rtl/pps_sync_rx.sv | 195 +++++++++++++++++++
 tb/tb_pps_sync_rx.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/pps_sync_rx.sv
// -----------------------------------------------------------------------------
// pps_sync_rx
//
// Purpose:
//   Receives an external pulse-per-second signal that is asynchronous to CLK.
//   It synchronizes the signal, detects rising edges, and measures the
//   edge-to-edge period. It locks after LOCK_CNT consecutive periods within
//   NOM_PERIOD +/- TOL, and while locked it counts the accepted seconds.
//   A missing edge (counter reaches NOM_PERIOD+TOL) drops the receiver back
//   to IDLE and raises a one-cycle miss strobe.
//
// Ports:
//   CLK          in   1   sole clock, rising edge
//   RST_N        in   1   synchronous active-low reset
//   pps_in       in   1   external PPS, asynchronous to CLK
//   enable       in   1   receiver enable (0 forces IDLE, strobes low)
//   pps_pulse    out  1   one-cycle strobe per synchronized rising edge
//   period       out  32  last measured edge-to-edge period in CLK cycles
//   period_valid out  1   one-cycle strobe when period updates
//   locked       out  1   high while the receiver is LOCKED
//   miss         out  1   one-cycle strobe on timeout
//   sec_count    out  32  accepted edges while LOCKED (wraps)
// -----------------------------------------------------------------------------
module pps_sync_rx #(
  parameter int unsigned NOM_PERIOD = 125000000,
  parameter int unsigned TOL        = 1000,
  parameter int unsigned LOCK_CNT   = 4
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        pps_in,
  input  logic        enable,
  output logic        pps_pulse,
  output logic [31:0] period,
  output logic        period_valid,
  output logic        locked,
  output logic        miss,
  output logic [31:0] sec_count
);

  localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);
  localparam logic [31:0] CNT_MIN = 32'(NOM_PERIOD - TOL);
  localparam logic [31:0] CNT_MAX = 32'(NOM_PERIOD + TOL);
  localparam logic [GOOD_W-1:0] GOOD_LOCK = GOOD_W'(LOCK_CNT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACQ    = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  logic              prev_q, prev_d;
  state_e            state_q, state_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [GOOD_W-1:0] good_q, good_d;
  logic              pps_pulse_q, pps_pulse_d;
  logic [31:0]       period_q, period_d;
  logic              period_valid_q, period_valid_d;
  logic              locked_q, locked_d;
  logic              miss_q, miss_d;
  logic [31:0]       sec_count_q, sec_count_d;

  logic              edge_s;
  logic              in_tol_s;
  logic              running_s;
  logic [GOOD_W-1:0] good_inc_s;

  // Edge qualification and period tolerance decode.
  always_comb begin
    // prev_q keeps tracking the synchronizer while disabled. As a result, a
    // level that is already high when enable returns does not count as an edge.
    edge_s     = enable & sync2_q & ~prev_q;
    in_tol_s   = (cnt_q >= CNT_MIN) && (cnt_q <= CNT_MAX);
    running_s  = (state_q == ST_ACQ) || (state_q == ST_LOCKED);
    good_inc_s = good_q + GOOD_W'(1);
  end

  // Next-state logic for the synchronizer, the period counter and the FSM.
  always_comb begin
    sync1_d        = pps_in;
    sync2_d        = sync1_q;
    prev_d         = sync2_q;
    state_d        = state_q;
    cnt_d          = cnt_q;
    good_d         = good_q;
    pps_pulse_d    = 1'b0;
    period_d       = period_q;
    period_valid_d = 1'b0;
    miss_d         = 1'b0;
    sec_count_d    = sec_count_q;
    // locked follows the registered state. Dropping enable clears it at once.
    locked_d       = enable && (state_q == ST_LOCKED);

    if (!enable) begin
      state_d = ST_IDLE;
      cnt_d   = 32'd0;
      good_d  = '0;
    end else if (edge_s) begin
      pps_pulse_d = 1'b1;
      cnt_d       = 32'd1;
      case (state_q)
        ST_IDLE: begin
          state_d = ST_ACQ;
          good_d  = '0;
        end
        ST_ACQ: begin
          period_d       = cnt_q;
          period_valid_d = 1'b1;
          if (in_tol_s) begin
            if (good_inc_s == GOOD_LOCK) begin
              state_d = ST_LOCKED;
              good_d  = GOOD_LOCK;
            end else begin
              state_d = ST_ACQ;
              good_d  = good_inc_s;
            end
          end else begin
            state_d = ST_ACQ;
            good_d  = '0;
          end
        end
        ST_LOCKED: begin
          period_d       = cnt_q;
          period_valid_d = 1'b1;
          if (in_tol_s) begin
            state_d     = ST_LOCKED;
            sec_count_d = sec_count_q + 32'd1;
          end else begin
            state_d = ST_ACQ;
            good_d  = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          good_d  = '0;
        end
      endcase
    end else if (running_s) begin
      cnt_d = cnt_q + 32'd1;
      // An edge in this same cycle would have taken the branch above. This
      // gives the edge priority over the timeout at the upper bound.
      if (cnt_q == CNT_MAX) begin
        state_d = ST_IDLE;
        good_d  = '0;
        miss_d  = 1'b1;
      end else begin
        state_d = state_q;
        good_d  = good_q;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // All state registers, with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sync1_q        <= 1'b0;
      sync2_q        <= 1'b0;
      prev_q         <= 1'b0;
      state_q        <= ST_IDLE;
      cnt_q          <= 32'd0;
      good_q         <= '0;
      pps_pulse_q    <= 1'b0;
      period_q       <= 32'd0;
      period_valid_q <= 1'b0;
      locked_q       <= 1'b0;
      miss_q         <= 1'b0;
      sec_count_q    <= 32'd0;
    end else begin
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      prev_q         <= prev_d;
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      good_q         <= good_d;
      pps_pulse_q    <= pps_pulse_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      locked_q       <= locked_d;
      miss_q         <= miss_d;
      sec_count_q    <= sec_count_d;
    end
  end

  assign pps_pulse    = pps_pulse_q;
  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign locked       = locked_q;
  assign miss         = miss_q;
  assign sec_count    = sec_count_q;

endmodule

// File: tb/tb_pps_sync_rx.sv
// -----------------------------------------------------------------------------
// tb_pps_sync_rx
//
// Directed bench for pps_sync_rx with NOM_PERIOD=100, TOL=2, LOCK_CNT=3.
// pps_in rises #1 after a clock edge. The pulse shows up after the third
// following edge, so the spacing between rises equals the measured period.
// -----------------------------------------------------------------------------
module tb_pps_sync_rx;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        pps_in;
  logic        enable;
  logic        pps_pulse;
  logic [31:0] period;
  logic        period_valid;
  logic        locked;
  logic        miss;
  logic [31:0] sec_count;

  int err_cnt = 0;
  int chk_cnt = 0;

  pps_sync_rx #(
    .NOM_PERIOD (100),
    .TOL        (2),
    .LOCK_CNT   (3)
  ) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .pps_in       (pps_in),
    .enable       (enable),
    .pps_pulse    (pps_pulse),
    .period       (period),
    .period_valid (period_valid),
    .locked       (locked),
    .miss         (miss),
    .sec_count    (sec_count)
  );

  // Free-running clock, 10 time-unit period.
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".pulse"},  {31'd0, pps_pulse},    32'd0);
    chk({tag, ".pv"},     {31'd0, period_valid}, 32'd0);
    chk({tag, ".miss"},   {31'd0, miss},         32'd0);
    chk({tag, ".locked"}, {31'd0, locked},       32'd0);
    chk({tag, ".period"}, period,                32'd0);
    chk({tag, ".sec"},    sec_count,             32'd0);
  endtask

  // One PPS edge: raise, check the pulse cycle, then the cycle after.
  // gap is the number of clocks until the next rise (>= 10).
  task automatic pps_edge(input string tag, input int gap, input logic exp_pv,
                          input logic [31:0] exp_per, input logic exp_lk,
                          input logic [31:0] exp_sec);
    pps_in = 1'b1;
    tick(3);
    chk({tag, ".pulse"},  {31'd0, pps_pulse},    32'd1);
    chk({tag, ".pv"},     {31'd0, period_valid}, {31'd0, exp_pv});
    chk({tag, ".period"}, period,                exp_per);
    chk({tag, ".miss"},   {31'd0, miss},         32'd0);
    tick(1);
    chk({tag, ".pulse1"}, {31'd0, pps_pulse},    32'd0);
    chk({tag, ".pv1"},    {31'd0, period_valid}, 32'd0);
    chk({tag, ".locked"}, {31'd0, locked},       {31'd0, exp_lk});
    chk({tag, ".sec"},    sec_count,             exp_sec);
    tick(6);
    pps_in = 1'b0;
    tick(gap - 10);
  endtask

  initial begin
    RST_N  = 1'b0;
    enable = 1'b1;
    pps_in = 1'b0;

    // Reset held for 5 cycles while pps_in toggles: everything stays zero.
    for (int i = 0; i < 5; i++) begin
      pps_in = ~pps_in;
      tick(1);
      chk_all_zero("rst");
    end
    pps_in = 1'b0;
    tick(1);
    RST_N = 1'b1;
    tick(4);
    chk("rst_rel.pulse", {31'd0, pps_pulse}, 32'd0);

    // Lock-in: edges 100 apart, LOCKED after the 4th edge.
    pps_edge("e1", 100, 1'b0, 32'd0,   1'b0, 32'd0);
    pps_edge("e2", 100, 1'b1, 32'd100, 1'b0, 32'd0);
    pps_edge("e3", 100, 1'b1, 32'd100, 1'b0, 32'd0);
    pps_edge("e4", 100, 1'b1, 32'd100, 1'b1, 32'd0);
    pps_edge("e5",  98, 1'b1, 32'd100, 1'b1, 32'd1);
    // Tolerance bounds: 98 and 102 accepted (102 also meets the timeout
    // point and must win over it), 97 drops to ACQ.
    pps_edge("e6", 102, 1'b1, 32'd98,  1'b1, 32'd2);
    pps_edge("e7",  97, 1'b1, 32'd102, 1'b1, 32'd3);
    pps_edge("e8", 100, 1'b1, 32'd97,  1'b0, 32'd3);
    // Relock from ACQ.
    pps_edge("e9",  100, 1'b1, 32'd100, 1'b0, 32'd3);
    pps_edge("e10", 100, 1'b1, 32'd100, 1'b0, 32'd3);
    pps_edge("e11",  10, 1'b1, 32'd100, 1'b1, 32'd3);

    // Timeout: the e11 pulse was 7 cycles ago with cnt=1. cnt reaches 102 and
    // miss is registered at the 102nd edge after the pulse.
    tick(94);
    chk("to.pre_miss",   {31'd0, miss},   32'd0);
    chk("to.pre_locked", {31'd0, locked}, 32'd1);
    tick(1);
    chk("to.miss",       {31'd0, miss},   32'd1);
    tick(1);
    chk("to.miss_once",  {31'd0, miss},   32'd0);
    chk("to.locked",     {31'd0, locked}, 32'd0);
    tick(10);
    // After the timeout the receiver is in IDLE, so the next edge carries no period.
    pps_edge("e12", 100, 1'b0, 32'd100, 1'b0, 32'd3);
    pps_edge("e13", 100, 1'b1, 32'd100, 1'b0, 32'd3);
    pps_edge("e14", 100, 1'b1, 32'd100, 1'b0, 32'd3);
    pps_edge("e15", 100, 1'b1, 32'd100, 1'b1, 32'd3);

    // Enable drop mid-LOCKED with pps_in held high.
    pps_in = 1'b1;
    tick(3);
    chk("en.e16_pulse",  {31'd0, pps_pulse}, 32'd1);
    chk("en.e16_sec",    sec_count,          32'd4);
    tick(1);
    chk("en.locked_pre", {31'd0, locked},    32'd1);
    enable = 1'b0;
    tick(1);
    chk("en.locked",     {31'd0, locked},       32'd0);
    chk("en.period",     period,                32'd100);
    chk("en.sec",        sec_count,             32'd4);
    chk("en.pv",         {31'd0, period_valid}, 32'd0);
    chk("en.miss",       {31'd0, miss},         32'd0);
    tick(5);
    chk("en.locked_hold", {31'd0, locked},      32'd0);
    enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("en.no_pulse", {31'd0, pps_pulse}, 32'd0);
    end
    pps_in = 1'b0;
    tick(4);
    pps_in = 1'b1;
    tick(3);
    chk("en.fresh_pulse", {31'd0, pps_pulse},    32'd1);
    chk("en.fresh_pv",    {31'd0, period_valid}, 32'd0);
    chk("en.fresh_per",   period,                32'd100);

    // Reset mid-operation with an edge already in the synchronizer.
    pps_in = 1'b0;
    tick(20);
    pps_in = 1'b1;
    tick(2);
    RST_N = 1'b0;
    tick(1);
    chk_all_zero("mrst");
    pps_in = 1'b0;
    tick(2);
    RST_N = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("mrst.no_pulse", {31'd0, pps_pulse}, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
